// File: rtl/conv_encoder_pkg.sv
// Shared encoder/decoder definitions: constraint length, default generators,
// symbol type and encoder FSM states.
package viterbi_pkg;

  localparam int unsigned K = 3;
  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } enc_state_e;

  // Tap vector is {u, s1, s2}; bit 2 is the current input.
  function automatic logic parity(input logic [K-1:0] taps, input logic [K-1:0] g);
    return ^(taps & g);
  endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Frame request / symbol handshake bundle between the encoder and its neighbours.
interface conv_encoder_if #(
  parameter int unsigned SIZE_DATA_IN = 8
);
  import viterbi_pkg::*;

  logic                    i_start;
  logic [SIZE_DATA_IN-1:0] i_data;
  logic                    i_ready;
  sym_t                    o_data;
  logic                    o_valid;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    output i_start, i_data, i_ready,
    input  o_data, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_data, i_ready,
    output o_data, o_valid, o_busy, o_done
  );

endinterface

// File: rtl/conv_encoder_core.sv
// Combinational rate-1/2 K=3 trellis step: {u,s1,s2} -> {c0,c1} and next state.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic       i_u,
  input  logic [1:0] i_state,
  output sym_t       o_sym,
  output logic [1:0] o_next_state
);

  logic [K-1:0] w_taps;

  assign w_taps       = {i_u, i_state};
  assign o_sym        = {parity(w_taps, G0), parity(w_taps, G1)};
  assign o_next_state = {i_u, i_state[1]};

endmodule

// File: rtl/conv_encoder.sv
// Frame-based convolutional encoder: captures a word, emits MSB-first code symbols.
// Define CONV_ENC_TAIL_EN to append two zero tail bits terminating the trellis in state 0.
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int unsigned  SIZE_DATA_IN = 8,
  parameter logic [K-1:0] G0           = G0_DEFAULT,
  parameter logic [K-1:0] G1           = G1_DEFAULT
) (
  input logic           i_clk,
  input logic           i_rst,
  conv_encoder_if.slave bus
);

  localparam int unsigned CW = $clog2(SIZE_DATA_IN + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(SIZE_DATA_IN - 1);

  enc_state_e              r_state;
  logic [SIZE_DATA_IN-1:0] r_payload;
  logic [1:0]              r_enc_st;
  logic [CW-1:0]           r_count;

  logic       w_valid;
  logic       w_u;
  logic       w_hs;
  sym_t       w_sym;
  logic [1:0] w_next_st;

  assign w_valid = (r_state == ENC) || (r_state == TAIL);
  assign w_u     = (r_state == ENC) ? r_payload[SIZE_DATA_IN-1] : 1'b0;
  assign w_hs    = w_valid && bus.i_ready;

  conv_enc_core #(
    .G0(G0),
    .G1(G1)
  ) u_core (
    .i_u          (w_u),
    .i_state      (r_enc_st),
    .o_sym        (w_sym),
    .o_next_state (w_next_st)
  );

  assign bus.o_data  = w_valid ? w_sym : '0;
  assign bus.o_valid = w_valid;
  assign bus.o_busy  = (r_state != IDLE);
  assign bus.o_done  = (r_state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_payload <= '0;
      r_enc_st  <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_payload <= bus.i_data;
            r_enc_st  <= '0;
            r_count   <= '0;
            r_state   <= ENC;
          end
        end
        ENC: begin
          if (w_hs) begin
            r_payload <= r_payload << 1;
            r_enc_st  <= w_next_st;
            if (r_count == LAST_DATA) begin
              // Counter is reused for the tail so it never needs to exceed SIZE_DATA_IN-1.
              r_count <= '0;
`ifdef CONV_ENC_TAIL_EN
              r_state <= TAIL;
`else
              r_state <= DONE;
`endif
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
`ifdef CONV_ENC_TAIL_EN
        TAIL: begin
          if (w_hs) begin
            r_enc_st <= w_next_st;
            if (r_count == CW'(1)) begin
              r_count <= '0;
              r_state <= DONE;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: symbol-list reference model plus literal frame pins.
module tb_conv_encoder;
  import viterbi_pkg::*;

  localparam int unsigned N = 8;
`ifdef CONV_ENC_TAIL_EN
  localparam int unsigned TAILN = 2;
`else
  localparam int unsigned TAILN = 0;
`endif
  localparam int unsigned NSYM = N + TAILN;

  logic clk = 1'b0;
  logic rst;

  conv_encoder_if #(.SIZE_DATA_IN(N)) bus ();

  conv_encoder #(
    .SIZE_DATA_IN (N),
    .G0           (3'b111),
    .G1           (3'b101)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;
  int done_rel = -1;
  logic [1:0] cap_sym[$];
  int cap_rel[$];

  // Reference model state: 0 idle, 1 emitting symbols, 2 done pulse.
  int m_phase = 0;
  int unsigned m_idx = 0;
  logic [N-1:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit k of the transmitted stream: payload MSB first, then zeros.
  function automatic logic stream_bit(input logic [N-1:0] d, input int k);
    if (k < 0 || k >= int'(N)) return 1'b0;
    return d[N-1-k];
  endfunction

  function automatic logic [1:0] ref_sym(input logic [N-1:0] d, input int unsigned i);
    logic u, s1, s2;
    u  = stream_bit(d, int'(i));
    s1 = stream_bit(d, int'(i) - 1);
    s2 = stream_bit(d, int'(i) - 2);
    return {u ^ s1 ^ s2, u ^ s2};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_phase <= 0;
      m_idx   <= 0;
    end else begin
      case (m_phase)
        0: if (bus.i_start) begin
             m_data  <= bus.i_data;
             m_idx   <= 0;
             m_phase <= 1;
           end
        1: if (bus.i_ready) begin
             m_idx <= m_idx + 1;
             if (m_idx + 1 == NSYM) m_phase <= 2;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(bus.o_valid), 32'(m_phase == 1));
    check("data",  32'(bus.o_data),  32'((m_phase == 1) ? ref_sym(m_data, m_idx) : 2'b00));
    check("busy",  32'(bus.o_busy),  32'(m_phase != 0));
    check("done",  32'(bus.o_done),  32'(m_phase == 2));
    if (bus.o_valid && bus.i_ready) begin
      cap_sym.push_back(bus.o_data);
      cap_rel.push_back(cyc - t_start);
    end
    if (bus.o_done) done_rel <= cyc - t_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.i_start = 1'b0;
      bus.i_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Runs one frame; returns during the o_done cycle.
  task automatic frame(input logic [N-1:0] d, input int st_lo, input int st_hi,
                       input bit rnd, input int j1, input int j2);
    int r;
    tick();
    bus.i_start = 1'b1;
    bus.i_data  = d;
    bus.i_ready = 1'b1;
    t_start     = cyc;
    done_rel    = -1;
    cap_sym.delete();
    cap_rel.delete();
    r = 0;
    while (1) begin
      tick();
      r++;
      bus.i_start = (r == j1) || (r == j2);
      bus.i_data  = bus.i_start ? ~d : N'($urandom);
      if (r >= st_lo && r <= st_hi) bus.i_ready = 1'b0;
      else if (rnd)                 bus.i_ready = ($urandom_range(0, 3) != 0);
      else                          bus.i_ready = 1'b1;
      if (bus.o_done) break;
      if (r > 400) begin
        check("frame_timeout", 32'(r), 32'(0));
        break;
      end
    end
  endtask

  logic [1:0] lit_b0[10];
  logic [1:0] lit_ff[10];

  task automatic check_lit(input string tag, input bit use_ff, input int exp_done);
    #6;
    check({tag, "_count"}, 32'(cap_sym.size()), 32'(NSYM));
    for (int unsigned i = 0; i < NSYM && i < cap_sym.size(); i++)
      check({tag, "_sym"}, 32'(cap_sym[i]), 32'(use_ff ? lit_ff[i] : lit_b0[i]));
    check({tag, "_done_cycle"}, 32'(done_rel), 32'(exp_done));
  endtask

  initial begin
    int t1;
    logic [N-1:0] d;
    lit_b0 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    lit_ff = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;

    for (int unsigned i = 0; i < NSYM; i++) begin
      check("model_b0", 32'(ref_sym(8'hB0, i)), 32'(lit_b0[i]));
      check("model_ff", 32'(ref_sym(8'hFF, i)), 32'(lit_ff[i]));
    end

    repeat (3) tick();
    check("reset_valid", 32'(bus.o_valid), 32'(0));
    check("reset_data",  32'(bus.o_data),  32'(0));
    check("reset_busy",  32'(bus.o_busy),  32'(0));
    check("reset_done",  32'(bus.o_done),  32'(0));
    rst = 1'b0;
    idle(2);

    frame(8'hB0, -1, -1, 1'b0, -1, -1);
    check_lit("b0", 1'b0, int'(NSYM) + 1);
    idle(1);

    frame(8'hFF, -1, -1, 1'b0, -1, -1);
    check_lit("ff", 1'b1, int'(NSYM) + 1);
    idle(1);

    frame(8'hB0, 3, 5, 1'b0, -1, -1);
    check_lit("stall", 1'b0, int'(NSYM) + 4);
    idle(1);

    frame(8'hB0, -1, -1, 1'b0, 2, int'(NSYM) + 1);
    check_lit("ignore", 1'b0, int'(NSYM) + 1);
    t1 = t_start;
    frame(8'h5A, -1, -1, 1'b0, -1, -1);
    check("restart_first_sym", 32'(t_start - t1 + cap_rel[0]), 32'(NSYM + 3));
    idle(1);

    // Reset mid-frame, then confirm the next frame encodes from state 0.
    tick();
    bus.i_start = 1'b1;
    bus.i_data  = 8'h3C;
    bus.i_ready = 1'b1;
    t_start = cyc;
    for (int r = 1; r <= 5; r++) begin
      tick();
      bus.i_start = 1'b0;
      if (r == 5) rst = 1'b1;
    end
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(bus.o_valid), 32'(0));
    check("midrst_data",  32'(bus.o_data),  32'(0));
    check("midrst_busy",  32'(bus.o_busy),  32'(0));
    check("midrst_done",  32'(bus.o_done),  32'(0));
    frame(8'hB0, -1, -1, 1'b0, -1, -1);
    check_lit("after_rst", 1'b0, int'(NSYM) + 1);

    for (int k = 0; k < 30; k++) begin
      idle($urandom_range(0, 3));
      d = N'($urandom);
      frame(d, -1, -1, 1'b1, $urandom_range(1, NSYM + 1), $urandom_range(1, NSYM + 1));
      #6;
      check("rand_count", 32'(cap_sym.size()), 32'(NSYM));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
